// File: rtl/product_accumulator_pkg.sv
// Shared definitions for the product accumulator: FSM encoding and the
// default widths used by the multiplier top level.
`timescale 1ns/1ps
package product_accumulator_pkg;

   localparam int DEF_PW = 32;
   localparam int DEF_AW = 40;
   localparam int DEF_CW = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

endpackage

// File: rtl/product_accumulator_if.sv
// Product stream in, result stream out, both valid/ready.
// Master is the multiplier/consumer side, slave is the accumulator.
`timescale 1ns/1ps
interface product_accumulator_if
   import product_accumulator_pkg::*;
#(
   parameter int PW = DEF_PW,
   parameter int AW = DEF_AW,
   parameter int CW = DEF_CW
);

   // Valid/ready: a transfer happens on a rising clock edge where valid and
   // ready are both high; the source holds its payload stable until then.
   logic          in_valid;
   logic          in_ready;
   logic [PW-1:0] in_product;
   logic          in_last;

   logic          out_valid;
   logic          out_ready;
   logic [AW-1:0] out_sum;
   logic [CW-1:0] out_count;
   logic          out_ovf;

   modport master (
      output in_valid, in_product, in_last, out_ready,
      input  in_ready, out_valid, out_sum, out_count, out_ovf
   );

   modport slave (
      input  in_valid, in_product, in_last, out_ready,
      output in_ready, out_valid, out_sum, out_count, out_ovf
   );

endinterface

// File: rtl/product_accumulator_sat_adder.sv
// Unsigned AW-bit accumulate of a PW-bit addend with sticky saturation:
// once overflowed (or told so via i_sticky) the sum pins to all-ones.
`timescale 1ns/1ps
module product_accumulator_sat_adder #(
   parameter int PW = 32,
   parameter int AW = 40
) (
   input  logic [AW-1:0] i_acc,
   input  logic [PW-1:0] i_addend,
   input  logic          i_sticky,
   output logic [AW-1:0] o_sum,
   output logic          o_ovf
);

   logic [AW:0] w_wide;

   // One extra bit catches the carry out of the accumulator width.
   assign w_wide = {1'b0, i_acc} + (AW+1)'(i_addend);
   assign o_ovf  = w_wide[AW] | i_sticky;
   assign o_sum  = o_ovf ? '1 : w_wide[AW-1:0];

endmodule

// File: rtl/product_accumulator.sv
// Sums a stream of unsigned products per vector (in_last marks the end) and
// presents one saturated sum, beat count and overflow flag per vector.
`timescale 1ns/1ps
module product_accumulator
   import product_accumulator_pkg::*;
#(
   parameter int PW = DEF_PW,
   parameter int AW = DEF_AW,
   parameter int CW = DEF_CW
) (
   input  logic                clk,
   input  logic                rst_n,
   product_accumulator_if.slave bus,
   output state_e              o_state
);

   state_e        r_state;
   logic [AW-1:0] r_acc;
   logic [CW-1:0] r_count;
   logic          r_ovf;
   logic [AW-1:0] r_out_sum;
   logic [CW-1:0] r_out_count;
   logic          r_out_ovf;

   state_e        w_state_nxt;
   logic [AW-1:0] w_acc_nxt;
   logic [CW-1:0] w_count_nxt;
   logic          w_ovf_nxt;
   logic          w_out_ld;
   logic [AW-1:0] w_out_sum_nxt;
   logic [CW-1:0] w_out_count_nxt;
   logic          w_out_ovf_nxt;

   logic          w_out_valid;
   logic          w_in_ready;
   logic          w_in_fire;
   logic          w_out_fire;
   logic          w_start;
   logic [AW-1:0] w_add_sum;
   logic          w_add_ovf;
   logic [CW-1:0] w_count_inc;

   // A held result can be replaced in the same cycle it is consumed, so the
   // input side never bubbles while the consumer keeps up.
   assign w_out_valid = (r_state == ST_DONE);
   assign w_in_ready  = !w_out_valid || bus.out_ready;
   assign w_in_fire   = bus.in_valid && w_in_ready;
   assign w_out_fire  = w_out_valid && bus.out_ready;
   assign w_count_inc = (r_count == '1) ? r_count : r_count + CW'(1);

   product_accumulator_sat_adder #(
      .PW (PW),
      .AW (AW)
   ) u_sat_adder (
      .i_acc    (r_acc),
      .i_addend (bus.in_product),
      .i_sticky (r_ovf),
      .o_sum    (w_add_sum),
      .o_ovf    (w_add_ovf)
   );

   always_comb begin
      w_state_nxt     = r_state;
      w_acc_nxt       = r_acc;
      w_count_nxt     = r_count;
      w_ovf_nxt       = r_ovf;
      w_out_ld        = 1'b0;
      w_out_sum_nxt   = r_out_sum;
      w_out_count_nxt = r_out_count;
      w_out_ovf_nxt   = r_out_ovf;
      w_start         = 1'b0;

      case (r_state)
         ST_IDLE: begin
            w_start = w_in_fire;
         end
         ST_ACCUM: begin
            if (w_in_fire) begin
               if (bus.in_last) begin
                  w_out_ld        = 1'b1;
                  w_out_sum_nxt   = w_add_sum;
                  w_out_count_nxt = w_count_inc;
                  w_out_ovf_nxt   = w_add_ovf;
                  w_acc_nxt       = '0;
                  w_count_nxt     = '0;
                  w_ovf_nxt       = 1'b0;
                  w_state_nxt     = ST_DONE;
               end else begin
                  w_acc_nxt   = w_add_sum;
                  w_count_nxt = w_count_inc;
                  w_ovf_nxt   = w_add_ovf;
               end
            end
         end
         ST_DONE: begin
            if (w_out_fire) begin
               w_start = w_in_fire;
               if (!w_in_fire) begin
                  w_state_nxt = ST_IDLE;
               end
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase

      // First beat of a vector, taken from IDLE or straight out of DONE.
      if (w_start) begin
         w_ovf_nxt = 1'b0;
         if (bus.in_last) begin
            w_out_ld        = 1'b1;
            w_out_sum_nxt   = AW'(bus.in_product);
            w_out_count_nxt = CW'(1);
            w_out_ovf_nxt   = 1'b0;
            w_acc_nxt       = '0;
            w_count_nxt     = '0;
            w_state_nxt     = ST_DONE;
         end else begin
            w_acc_nxt   = AW'(bus.in_product);
            w_count_nxt = CW'(1);
            w_state_nxt = ST_ACCUM;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc       <= '0;
         r_count     <= '0;
         r_ovf       <= 1'b0;
         r_out_sum   <= '0;
         r_out_count <= '0;
         r_out_ovf   <= 1'b0;
      end else begin
         r_acc   <= w_acc_nxt;
         r_count <= w_count_nxt;
         r_ovf   <= w_ovf_nxt;
         if (w_out_ld) begin
            r_out_sum   <= w_out_sum_nxt;
            r_out_count <= w_out_count_nxt;
            r_out_ovf   <= w_out_ovf_nxt;
         end
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = w_out_valid;
   assign bus.out_sum   = r_out_sum;
   assign bus.out_count = r_out_count;
   assign bus.out_ovf   = r_out_ovf;
   assign o_state       = r_state;

endmodule
